vga_timing_gen: RTL and testbench

//  Raster timing generator for 640x480@60 VGA, clocked by the 25.2 MHz pixel clock

---
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator (default 640x480@60): registered syncs, data-enable, coordinates and strobes.
// Define TEST_PATTERN_EN to add the rgb port with an 8-bar colour source.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk_in,
    input  logic        resetn,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        line_start,
`ifdef TEST_PATTERN_EN
    output logic        frame_start,
    output logic [11:0] rgb
`else
    output logic        frame_start
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_S = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_E = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_h;
    logic [10:0] r_v;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_de;
    logic        w_hs_act;
    logic        w_vs_act;

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);
    assign w_de     = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs_act = (r_h >= H_SYNC_S) && (r_h < H_SYNC_E);
    assign w_vs_act = (r_v >= V_SYNC_S) && (r_v < V_SYNC_E);

    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            r_h <= '0;
            r_v <= '0;
        end else if (en) begin
            if (w_h_wrap) begin
                r_h <= '0;
                r_v <= w_v_wrap ? 11'd0 : r_v + 11'd1;
            end else begin
                r_h <= r_h + 11'd1;
            end
        end
    end

    // Outputs are a registered decode of the counters, so all of them share one cycle of latency.
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            de          <= w_de;
            x           <= r_h;
            y           <= r_v;
            line_start  <= (r_h == 11'd0);
            frame_start <= (r_h == 11'd0) && (r_v == 11'd0);
        end
    end

`ifdef TEST_PATTERN_EN
    localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

    logic [10:0] r_bar_cnt;
    logic [2:0]  r_bar_idx;
    logic [11:0] w_bar_rgb;

    // Bar index tracks r_h through the active region; it wraps harmlessly in blanking where rgb is forced to 0.
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (en) begin
            if (w_h_wrap) begin
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
            end else if (r_h < H_ACT) begin
                if (r_bar_cnt == BAR_LAST) begin
                    r_bar_cnt <= '0;
                    r_bar_idx <= r_bar_idx + 3'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + 11'd1;
                end
            end
        end
    end

    always_comb begin
        w_bar_rgb = 12'h000;
        case (r_bar_idx)
            3'd0: w_bar_rgb = 12'hFFF;
            3'd1: w_bar_rgb = 12'hFF0;
            3'd2: w_bar_rgb = 12'h0FF;
            3'd3: w_bar_rgb = 12'h0F0;
            3'd4: w_bar_rgb = 12'hF0F;
            3'd5: w_bar_rgb = 12'hF00;
            3'd6: w_bar_rgb = 12'h00F;
            default: w_bar_rgb = 12'h000;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            rgb <= '0;
        end else if (en) begin
            rgb <= w_de ? w_bar_rgb : 12'h000;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small-raster instance share the stimulus.
// Expected outputs come from a reference decode pushed to a scoreboard queue each edge.
module tb_vga_timing_gen;

    localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
        logic [11:0] rgb;
    } out_t;

    typedef struct packed {
        out_t a;
        out_t b;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, en;
    logic d0_hsync, d0_vsync, d0_de, d0_ls, d0_fs;
    logic [10:0] d0_x, d0_y;
    logic d1_hsync, d1_vsync, d1_de, d1_ls, d1_fs;
    logic [10:0] d1_x, d1_y;
`ifdef TEST_PATTERN_EN
    logic [11:0] d0_rgb, d1_rgb;
`endif

    vga_timing_gen u_dut0 (
        .clk_in(clk), .resetn(resetn), .en(en),
        .hsync(d0_hsync), .vsync(d0_vsync), .de(d0_de),
        .x(d0_x), .y(d0_y), .line_start(d0_ls),
`ifdef TEST_PATTERN_EN
        .frame_start(d0_fs), .rgb(d0_rgb)
`else
        .frame_start(d0_fs)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_dut1 (
        .clk_in(clk), .resetn(resetn), .en(en),
        .hsync(d1_hsync), .vsync(d1_vsync), .de(d1_de),
        .x(d1_x), .y(d1_y), .line_start(d1_ls),
`ifdef TEST_PATTERN_EN
        .frame_start(d1_fs), .rgb(d1_rgb)
`else
        .frame_start(d1_fs)
`endif
    );

    pair_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m0h = 0, m0v = 0, m1h = 0, m1v = 0;
    out_t  last0, last1;

    function automatic logic [11:0] bar_col(input int i);
        case (i)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic out_t decode(input int h, input int v, input int ha, input int hf, input int hsw,
                                    input int va, input int vf, input int vsw);
        out_t e;
        e.de  = (h < ha) && (v < va);
        e.hs  = !((h >= ha + hf) && (h < ha + hf + hsw));
        e.vs  = !((v >= va + vf) && (v < va + vf + vsw));
        e.x   = 11'(h);
        e.y   = 11'(v);
        e.ls  = (h == 0);
        e.fs  = (h == 0) && (v == 0);
`ifdef TEST_PATTERN_EN
        e.rgb = e.de ? bar_col(h / (ha / 8)) : 12'h000;
`else
        e.rgb = 12'h000;
`endif
        return e;
    endfunction

    function automatic out_t reset_val();
        out_t e;
        e     = '0;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        pair_t p;
        out_t  o0, o1;
        p = sb_q.pop_front();
        o0 = '{hs: d0_hsync, vs: d0_vsync, de: d0_de, x: d0_x, y: d0_y, ls: d0_ls, fs: d0_fs, rgb: 12'h000};
        o1 = '{hs: d1_hsync, vs: d1_vsync, de: d1_de, x: d1_x, y: d1_y, ls: d1_ls, fs: d1_fs, rgb: 12'h000};
`ifdef TEST_PATTERN_EN
        o0.rgb = d0_rgb;
        o1.rgb = d1_rgb;
`endif
        chk("dut0_outputs", 64'(o0), 64'(p.a));
        chk("dut1_outputs", 64'(o1), 64'(p.b));
    endtask

    task automatic step(input logic r, input logic e_in);
        pair_t p;
        resetn = r;
        en     = e_in;
        if (!r) begin
            last0 = reset_val();
            last1 = reset_val();
            m0h = 0; m0v = 0; m1h = 0; m1v = 0;
        end else if (e_in) begin
            last0 = decode(m0h, m0v, 640, 16, 96, 480, 10, 2);
            last1 = decode(m1h, m1v, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS);
            if (m0h == 799) begin
                m0h = 0;
                m0v = (m0v == 524) ? 0 : m0v + 1;
            end else m0h++;
            if (m1h == S_HT - 1) begin
                m1h = 0;
                m1v = (m1v == S_VT - 1) ? 0 : m1v + 1;
            end else m1h++;
        end
        p.a = last0;
        p.b = last1;
        sb_q.push_back(p);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    int ls_seen = 0, de_cnt = 0, hs_cnt = 0, hs_first = -1, lper = 0;
    int fs_seen = 0, vs_cnt = 0, vs_fy = -1, vs_fx = -1, fper = 0;
    bit found;

    initial begin
        resetn = 1'b0;
        en     = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // Steady run: per-line and per-frame measurements taken from the observed outputs.
        for (int i = 0; i < 2405; i++) begin
            step(1'b1, 1'b1);
            if (d0_ls) begin
                if (ls_seen > 0) begin
                    chk("line_de_cycles", 64'(de_cnt), 64'd640);
                    chk("line_hsync_cycles", 64'(hs_cnt), 64'd96);
                    chk("line_hsync_start_x", 64'(hs_first), 64'd656);
                    chk("line_period", 64'(lper), 64'd800);
                end
                ls_seen++;
                de_cnt = 0; hs_cnt = 0; hs_first = -1; lper = 0;
            end
            lper++;
            if (d0_de) de_cnt++;
            if (!d0_hsync) begin
                if (hs_first < 0) hs_first = int'(d0_x);
                hs_cnt++;
            end
            if (d1_fs) begin
                if (fs_seen > 0) begin
                    chk("frame_period", 64'(fper), 64'(S_HT * S_VT));
                    chk("frame_vsync_cycles", 64'(vs_cnt), 64'(S_VS * S_HT));
                    chk("frame_vsync_start_y", 64'(vs_fy), 64'(S_VA + S_VF));
                    chk("frame_vsync_start_x", 64'(vs_fx), 64'd0);
                end
                fs_seen++;
                vs_cnt = 0; vs_fy = -1; vs_fx = -1; fper = 0;
            end
            fper++;
            if (!d1_vsync) begin
                if (vs_fy < 0) begin
                    vs_fy = int'(d1_y);
                    vs_fx = int'(d1_x);
                end
                vs_cnt++;
            end
        end
        chk("lines_measured", 64'(ls_seen), 64'd4);

        // Freeze with en low while the default instance shows x=100.
        found = 1'b0;
        for (int i = 0; i < 900 && !found; i++) begin
            step(1'b1, 1'b1);
            if (last0.x == 11'd100) found = 1'b1;
        end
        chk("reach_x100", 64'(found), 64'd1);
        for (int i = 0; i < 37; i++) step(1'b1, 1'b0);
        chk("frozen_x", 64'(d0_x), 64'd100);
        step(1'b1, 1'b1);
        chk("resume_x", 64'(d0_x), 64'd101);

        for (int i = 0; i < 300; i++) step(1'b1, ($urandom_range(0, 3) != 0));

        // Mid-frame reset on the small raster, once with en high and once with en low.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b1, 1'b1);
            if (last1.y == 11'd5 && last1.x == 11'd12) found = 1'b1;
        end
        chk("reach_y5_x12", 64'(found), 64'd1);
        step(1'b0, 1'b1);
        chk("midreset_de_x_y", 64'({d1_de, d1_x, d1_y}), 64'd0);
        chk("midreset_syncs", 64'({d1_hsync, d1_vsync}), 64'b11);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("post_reset_fs_de", 64'({d0_fs, d0_de, d1_fs, d1_de}), 64'hF);

        // Frame wrap on the small raster.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b1, 1'b1);
            if (last1.x == 11'(S_HT - 1) && last1.y == 11'(S_VT - 1)) found = 1'b1;
        end
        chk("reach_wrap", 64'(found), 64'd1);
        step(1'b1, 1'b1);
        chk("wrap_xy_strobes", 64'({d1_x, d1_y, d1_fs, d1_ls}), 64'({22'd0, 2'b11}));
        for (int i = 0; i < 3 * S_HT * S_VT; i++) step(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
